sextium_io_buffer: RTL and testbench
====================================

# sextium_io_buffer

Parametrised, buffered I/O device for the Sextium III core, replacing the behavioural I/O model used in simulation with synthesisable RTL. Sits on the core's I/O port (io_read/io_write/ioack plus data bus) and decouples it from an external stream producer and consumer through two FIFOs. The core's READ stalls until input data exists; its WRITE stalls until output space exists. Width and depth are generic.

## Interface
- WIDTH, 16: data word width (core bus and streams)
- DEPTH, 8: entries per FIFO; power of two, ≥2
- CW, $clog2(DEPTH+1): occupancy counter width (derived, not overridden)

- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- io_read  in  1  core requests one input word
- io_write  in  1  core offers one output word
- io_bus_in  in  WIDTH  core output data, valid while io_write
- io_bus_out  out  WIDTH  word returned to core, valid in ack cycle
- ioack  out  1  one-cycle acknowledge of current request
- rx_valid / rx_ready / rx_data  in / out / in WIDTH  external producer into RX FIFO
- tx_valid / tx_ready / tx_data  out / in / out WIDTH  TX FIFO to external consumer
- rx_count, tx_count  out  CW  current occupancies
- proto_err  out  1  sticky: io_read and io_write sampled high together

## Operation
- Reset: FIFOs empty, pointers 0, FSM IDLE; ioack=0, io_bus_out=0, rx_ready=1, tx_valid=0, tx_data=0, counts=0, proto_err=0.
- Streams: valid/ready; transfer when both high at rising edge. rx_ready = RX not full; tx_valid = TX not empty, tx_data = TX head (registered, first-word-fall-through).
- Core FSM states: IDLE, ACK, RELEASE.
  - IDLE, io_read only, RX non-empty: pop RX, latch head into io_bus_out, go ACK.
  - IDLE, io_write only, TX not full: push io_bus_in, go ACK.
  - IDLE, request but FIFO empty/full: stay IDLE (stall), ioack=0; retried every cycle.
  - IDLE, both requests: no transfer, set proto_err, stay IDLE.
  - ACK: ioack=1 for exactly this cycle; go RELEASE.
  - RELEASE: wait until io_read=0 and io_write=0, then IDLE. A held request is acknowledged once only.
- io_bus_out holds last read word until next read ack.
- proto_err cleared only by reset.

## Timing
- Request sampled at edge N with resource available -> ioack high in cycle after edge N (one-cycle latency), low after edge N+1.
- Minimum request-to-request spacing: 3 cycles (IDLE->ACK->RELEASE->IDLE with request dropped during ACK).
- RX push and core pop same edge: both occur; count unchanged; on empty RX, a pushed word is poppable from the next edge (no bypass).
- TX push from core and external pop same edge: both occur; when full, core push waits even if pop happens that edge (full evaluated pre-edge).
- Pointers wrap modulo DEPTH; counts reach exactly DEPTH at full.
- Reset mid-handshake: FSM to IDLE, ioack low next cycle, all buffered data discarded; a still-held request is treated as new after reset.

## Structure
- Package sextium_io_pkg: default WIDTH/DEPTH constants, FSM state enum (IDLE, ACK, RELEASE).
- Sub-module sextium_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count/head), instantiated as RX and TX; top holds FSM and proto_err.

## Test plan
- Reset, then io_read held with RX empty 10 cycles -> ioack stays 0; push rx_data=16'h1234 -> ioack pulses 2 cycles later, io_bus_out=16'h1234, rx_count 1->0.
- Core writes 16'hA001..A008 with tx_ready=0 (DEPTH=8) -> 8 acks, tx_count=8; 9th write stalls; raise tx_ready one cycle -> 9th acked, tx_data order A001 first.
- io_read held high 6 cycles with RX holding 3 words -> exactly one ack, rx_count 3->2.
- Push 20 words through RX while core reads continuously -> all 20 read in order, rx_ready never deasserted incorrectly, pointers wrap twice.
- io_read and io_write both high -> no ack, no FIFO change, proto_err=1 and stays 1 until reset.
- Assert reset in ACK cycle with tx_count=3 -> next cycle ioack=0, tx_count=0, tx_valid=0, proto_err=0.

Source files
------------

// File: rtl/sextium_io_pkg.sv
// Shared constants and FSM state type for the Sextium III buffered I/O device.
package sextium_io_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        RELEASE
    } io_state_e;

endpackage

// File: rtl/sextium_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head and occupancy count.
module sextium_sync_fifo
    import sextium_io_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Full/empty are judged before the edge, so a pop never makes room
    // for a push in the same cycle.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign count_d = count_q + CW'(push_ok) - CW'(pop_ok);

    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/sextium_io_buffer.sv
// Buffered core I/O port: RX/TX FIFOs between the core handshake and
// external valid/ready streams, with a three-state acknowledge FSM.
module sextium_io_buffer
    import sextium_io_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_read,
    input  logic             io_write,
    input  logic [WIDTH-1:0] io_bus_in,
    output logic [WIDTH-1:0] io_bus_out,
    output logic             ioack,
    input  logic             rx_valid,
    output logic             rx_ready,
    input  logic [WIDTH-1:0] rx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic [WIDTH-1:0] tx_data,
    output logic [CW-1:0]    rx_count,
    output logic [CW-1:0]    tx_count,
    output logic             proto_err
);

    io_state_e        state_q;
    logic             ioack_q;
    logic [WIDTH-1:0] bus_q;
    logic             perr_q;

    logic             rx_full;
    logic             rx_empty;
    logic [WIDTH-1:0] rx_head;
    logic             tx_full;
    logic             tx_empty;
    logic             rx_pop;
    logic             tx_push;

    assign rx_pop  = (state_q == IDLE) && io_read && !io_write && !rx_empty;
    assign tx_push = (state_q == IDLE) && io_write && !io_read && !tx_full;

    sextium_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_rx (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (rx_valid),
        .data_i  (rx_data),
        .pop_i   (rx_pop),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count),
        .head_o  (rx_head)
    );

    sextium_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_tx (
        .clk_i   (clock),
        .rst_i   (reset),
        .push_i  (tx_push),
        .data_i  (io_bus_in),
        .pop_i   (tx_ready),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count),
        .head_o  (tx_data)
    );

    assign rx_ready   = !rx_full;
    assign tx_valid   = !tx_empty;
    assign ioack      = ioack_q;
    assign io_bus_out = bus_q;
    assign proto_err  = perr_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            ioack_q <= 1'b0;
            bus_q   <= '0;
            perr_q  <= 1'b0;
        end else begin
            ioack_q <= 1'b0;
            if (io_read && io_write) begin
                perr_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (rx_pop) begin
                        bus_q   <= rx_head;
                        ioack_q <= 1'b1;
                        state_q <= ACK;
                    end else if (tx_push) begin
                        ioack_q <= 1'b1;
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    state_q <= RELEASE;
                end
                // A held request must drop before it can be served again.
                RELEASE: begin
                    if (!io_read && !io_write) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sextium_io_buffer.sv
// Directed bench for sextium_io_buffer: vector table plus corner sequences.
module tb_sextium_io_buffer;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int CW = 4;
    localparam int NV = 21;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          io_read = 1'b0;
    logic          io_write = 1'b0;
    logic [W-1:0]  io_bus_in = '0;
    logic [W-1:0]  io_bus_out;
    logic          ioack;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [W-1:0]  rx_data = '0;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic [W-1:0]  tx_data;
    logic [CW-1:0] rx_count;
    logic [CW-1:0] tx_count;
    logic          proto_err;

    sextium_io_buffer #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .io_read    (io_read),
        .io_write   (io_write),
        .io_bus_in  (io_bus_in),
        .io_bus_out (io_bus_out),
        .ioack      (ioack),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .rx_data    (rx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .rx_count   (rx_count),
        .tx_count   (tx_count),
        .proto_err  (proto_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [15:0]  din;
        logic         rxv;
        logic [15:0]  rxd;
        logic         txr;
        logic         ack;
        logic [15:0]  dout;
        logic [3:0]   rxc;
        logic [3:0]   txc;
        logic         txv;
        logic [15:0]  txd;
        logic         perr;
    } vec_t;

    vec_t tbl [NV];
    int checks = 0;
    int failures = 0;

    function automatic vec_t mk(
        input logic rd, input logic wr, input logic [15:0] din,
        input logic rxv, input logic [15:0] rxd, input logic txr,
        input logic ack, input logic [15:0] dout,
        input logic [3:0] rxc, input logic [3:0] txc,
        input logic txv, input logic [15:0] txd, input logic perr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.din = din;
        v.rxv = rxv; v.rxd = rxd; v.txr = txr;
        v.ack = ack; v.dout = dout; v.rxc = rxc; v.txc = txc;
        v.txv = txv; v.txd = txd; v.perr = perr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        io_read = 1'b0;
        io_write = 1'b0;
        io_bus_in = '0;
        rx_valid = 1'b0;
        rx_data = '0;
        tx_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    initial begin
        int acks;
        int cnt;
        int pushed;
        int got;
        int hold;
        logic push;
        logic pop;

        tbl[0]  = mk(0,0,16'h0,   0,16'h0,   0, 0,16'h0,   0,0,0,16'h0,   0);
        tbl[1]  = mk(0,0,16'h0,   1,16'h1111,0, 0,16'h0,   1,0,0,16'h0,   0);
        tbl[2]  = mk(0,0,16'h0,   1,16'h2222,0, 0,16'h0,   2,0,0,16'h0,   0);
        tbl[3]  = mk(1,0,16'h0,   0,16'h0,   0, 1,16'h1111,1,0,0,16'h0,   0);
        tbl[4]  = mk(0,0,16'h0,   0,16'h0,   0, 0,16'h1111,1,0,0,16'h0,   0);
        tbl[5]  = mk(1,0,16'h0,   0,16'h0,   0, 0,16'h1111,1,0,0,16'h0,   0);
        tbl[6]  = mk(0,0,16'h0,   0,16'h0,   0, 0,16'h1111,1,0,0,16'h0,   0);
        tbl[7]  = mk(1,0,16'h0,   0,16'h0,   0, 1,16'h2222,0,0,0,16'h0,   0);
        tbl[8]  = mk(0,0,16'h0,   0,16'h0,   0, 0,16'h2222,0,0,0,16'h0,   0);
        tbl[9]  = mk(0,0,16'h0,   0,16'h0,   0, 0,16'h2222,0,0,0,16'h0,   0);
        tbl[10] = mk(0,1,16'hBEEF,0,16'h0,   0, 1,16'h2222,0,1,1,16'hBEEF,0);
        tbl[11] = mk(0,0,16'h0,   0,16'h0,   0, 0,16'h2222,0,1,1,16'hBEEF,0);
        tbl[12] = mk(0,0,16'h0,   0,16'h0,   1, 0,16'h2222,0,0,0,16'h0,   0);
        tbl[13] = mk(1,1,16'h0,   0,16'h0,   0, 0,16'h2222,0,0,0,16'h0,   1);
        tbl[14] = mk(0,0,16'h0,   0,16'h0,   0, 0,16'h2222,0,0,0,16'h0,   1);
        tbl[15] = mk(1,0,16'h0,   1,16'h3333,0, 0,16'h2222,1,0,0,16'h0,   1);
        tbl[16] = mk(1,0,16'h0,   1,16'h4444,0, 1,16'h3333,1,0,0,16'h0,   1);
        tbl[17] = mk(0,0,16'h0,   0,16'h0,   0, 0,16'h3333,1,0,0,16'h0,   1);
        tbl[18] = mk(0,0,16'h0,   0,16'h0,   0, 0,16'h3333,1,0,0,16'h0,   1);
        tbl[19] = mk(1,0,16'h0,   0,16'h0,   0, 1,16'h4444,0,0,0,16'h0,   1);
        tbl[20] = mk(0,0,16'h0,   0,16'h0,   0, 0,16'h4444,0,0,0,16'h0,   1);

        do_reset();
        chk("rst_ack", ioack, 0);
        chk("rst_bus", io_bus_out, 0);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_tx_count", tx_count, 0);
        chk("rst_perr", proto_err, 0);

        for (int i = 0; i < NV; i++) begin
            io_read = tbl[i].rd;
            io_write = tbl[i].wr;
            io_bus_in = tbl[i].din;
            rx_valid = tbl[i].rxv;
            rx_data = tbl[i].rxd;
            tx_ready = tbl[i].txr;
            step();
            chk($sformatf("v%0d_ack", i), ioack, tbl[i].ack);
            chk($sformatf("v%0d_bus", i), io_bus_out, tbl[i].dout);
            chk($sformatf("v%0d_rxc", i), rx_count, tbl[i].rxc);
            chk($sformatf("v%0d_txc", i), tx_count, tbl[i].txc);
            chk($sformatf("v%0d_txv", i), tx_valid, tbl[i].txv);
            chk($sformatf("v%0d_txd", i), tx_data, tbl[i].txd);
            chk($sformatf("v%0d_perr", i), proto_err, tbl[i].perr);
            chk($sformatf("v%0d_rdy", i), rx_ready, 1);
        end

        // Read stalls on empty RX, then completes two edges after a push.
        do_reset();
        io_read = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("stall_ack", ioack, 0);
        end
        rx_valid = 1'b1;
        rx_data = 16'h1234;
        step();
        rx_valid = 1'b0;
        chk("a_push_ack", ioack, 0);
        chk("a_push_rxc", rx_count, 1);
        step();
        chk("a_ack", ioack, 1);
        chk("a_bus", io_bus_out, 16'h1234);
        chk("a_rxc", rx_count, 0);
        io_read = 1'b0;
        step();
        chk("a_ack_low", ioack, 0);

        // TX fill to DEPTH, ninth write stalls until the consumer drains.
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            io_write = 1'b1;
            io_bus_in = 16'(16'hA000 + i);
            step();
            chk("b_ack", ioack, 1);
            io_write = 1'b0;
            step();
            step();
        end
        chk("b_full_txc", tx_count, 8);
        chk("b_full_txd", tx_data, 16'hA001);
        chk("b_full_txv", tx_valid, 1);
        io_write = 1'b1;
        io_bus_in = 16'hA009;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("b_stall_ack", ioack, 0);
            chk("b_stall_txc", tx_count, 8);
        end
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("b_pop_ack", ioack, 0);
        chk("b_pop_txc", tx_count, 7);
        step();
        chk("b_9_ack", ioack, 1);
        chk("b_9_txc", tx_count, 8);
        chk("b_9_txd", tx_data, 16'hA002);
        io_write = 1'b0;
        step();
        step();
        tx_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            chk("b_drain", tx_data, 32'(16'hA000 + i));
            step();
        end
        tx_ready = 1'b0;
        chk("b_end_txv", tx_valid, 0);
        chk("b_end_txc", tx_count, 0);

        // A held read is acknowledged once only.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            rx_valid = 1'b1;
            rx_data = 16'(16'hC000 + i);
            step();
        end
        rx_valid = 1'b0;
        chk("c_rxc3", rx_count, 3);
        io_read = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ioack) acks++;
        end
        io_read = 1'b0;
        chk("c_acks", acks, 1);
        chk("c_rxc2", rx_count, 2);
        chk("c_bus", io_bus_out, 16'hC001);

        // Stream 20 words through RX against a continuously reading core.
        do_reset();
        cnt = 0;
        pushed = 0;
        got = 0;
        hold = 0;
        for (int cyc = 0; cyc < 400 && got < 20; cyc++) begin
            rx_valid = (pushed < 20);
            rx_data = 16'(16'h5000 + pushed);
            chk("d_rx_ready", rx_ready, (cnt < D));
            push = rx_valid && (cnt < D);
            io_read = (hold == 0);
            step();
            if (push) pushed++;
            pop = ioack;
            if (ioack) begin
                chk("d_order", io_bus_out, 32'(16'h5000 + got));
                got++;
                hold = 2;
            end else if (hold > 0) begin
                hold--;
            end
            cnt = cnt + int'(push) - int'(pop);
            chk("d_rxc", rx_count, cnt);
        end
        io_read = 1'b0;
        rx_valid = 1'b0;
        chk("d_got", got, 20);
        chk("d_pushed", pushed, 20);

        // Simultaneous requests: no transfer, sticky error.
        do_reset();
        rx_valid = 1'b1;
        rx_data = 16'h7777;
        step();
        rx_valid = 1'b0;
        io_read = 1'b1;
        io_write = 1'b1;
        io_bus_in = 16'h8888;
        step();
        chk("e_ack", ioack, 0);
        chk("e_perr", proto_err, 1);
        chk("e_rxc", rx_count, 1);
        chk("e_txc", tx_count, 0);
        io_read = 1'b0;
        io_write = 1'b0;
        step();
        step();
        step();
        chk("e_perr_sticky", proto_err, 1);

        // Reset landing in the ACK cycle with three words queued.
        for (int i = 0; i < 3; i++) begin
            io_write = 1'b1;
            io_bus_in = 16'(16'hF000 + i);
            step();
            chk("f_ack", ioack, 1);
            if (i < 2) begin
                io_write = 1'b0;
                step();
                step();
            end
        end
        chk("f_txc3", tx_count, 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("f_rst_ack", ioack, 0);
        chk("f_rst_txc", tx_count, 0);
        chk("f_rst_txv", tx_valid, 0);
        chk("f_rst_perr", proto_err, 0);
        chk("f_rst_rxc", rx_count, 0);
        step();
        chk("f_new_ack", ioack, 1);
        chk("f_new_txc", tx_count, 1);
        chk("f_new_txd", tx_data, 16'hF002);
        io_write = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
